// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request is presented with req/ready; the reply returns later on rvalid.
interface fetch_unit_if #(
    parameter int N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// and presents the fetched instruction to the Fetch-to-Decode register.
// Redirects from Decode (branch over jump) take effect in every state; a
// response already in flight for an old PC is dropped via the kill flag.
module fetch_unit #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         StallF,
    input  logic         PCSrcD,
    input  logic [N-1:0] PCBranchD,
    input  logic         JumpD,
    input  logic [N-1:0] PCJumpD,
    fetch_unit_if.master imem,
    output logic [N-1:0] InstrF,
    output logic [N-1:0] PCPlus4F,
    output logic         InstrValidF,
    output logic         FetchBusy
);

    localparam logic [N-1:0] PC_STEP = N'(4);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DELIVER
    } state_t;

    state_t       state;
    logic [N-1:0] pc;
    logic         kill;
    logic         req_q;
    logic         busy_q;

    logic         redirect;
    logic [N-1:0] target;

    // Redirect request and word-aligned target; branch wins over jump.
    always_comb begin
        redirect    = PCSrcD | JumpD;
        target      = PCSrcD ? PCBranchD : PCJumpD;
        target[1:0] = 2'b00;
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign FetchBusy      = busy_q;

    // Fetch FSM; req/busy are registered alongside the state they decode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            InstrF      <= '0;
            PCPlus4F    <= '0;
            InstrValidF <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    InstrValidF <= 1'b0;
                    state       <= REQ;
                    req_q       <= 1'b1;
                    busy_q      <= 1'b1;
                end

                REQ: begin
                    // An unaccepted request may simply retarget; an accepted
                    // one is already in flight, so its reply must be killed.
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem.imem_ready) begin
                        kill  <= redirect;
                        state <= WAIT;
                        req_q <= 1'b0;
                    end
                end

                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (redirect || kill) begin
                            if (redirect) begin
                                pc <= target;
                            end
                            kill  <= 1'b0;
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            InstrF      <= imem.imem_rdata;
                            PCPlus4F    <= pc + PC_STEP;
                            InstrValidF <= 1'b1;
                            state       <= DELIVER;
                            busy_q      <= 1'b0;
                        end
                    end else if (redirect) begin
                        pc   <= target;
                        kill <= 1'b1;
                    end
                end

                DELIVER: begin
                    if (redirect) begin
                        pc          <= target;
                        InstrValidF <= 1'b0;
                        state       <= REQ;
                        req_q       <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (!StallF) begin
                        pc          <= pc + PC_STEP;
                        InstrValidF <= 1'b0;
                        state       <= REQ;
                        req_q       <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    req_q  <= 1'b0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives the imem bus by hand cycle by cycle
// and compares outputs against hand-computed values.
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;
    logic        FetchBusy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    fetch_unit_if #(.N(32)) imem ();

    fetch_unit #(
        .N        (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .StallF      (StallF),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .JumpD       (JumpD),
        .PCJumpD     (PCJumpD),
        .imem        (imem.master),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF),
        .FetchBusy   (FetchBusy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST       = 1'b1;
        StallF    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = '0;
        JumpD     = 1'b0;
        PCJumpD   = '0;
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;

        tick();
        tick();
        check("rst_instr", InstrF, 32'h0);
        check("rst_pc4",   PCPlus4F, 32'h0);
        check("rst_valid", {31'b0, InstrValidF}, 32'd0);
        check("rst_req",   {31'b0, imem.imem_req}, 32'd0);
        check("rst_addr",  imem.imem_addr, 32'h0);
        check("rst_busy",  {31'b0, FetchBusy}, 32'd1);
        RST = 1'b0;

        // First fetch: IDLE -> REQ -> WAIT -> DELIVER.
        imem.imem_ready = 1'b1;
        tick();
        check("f1_req",  {31'b0, imem.imem_req}, 32'd1);
        check("f1_addr", imem.imem_addr, 32'h0);
        tick();
        check("f1_wait_req", {31'b0, imem.imem_req}, 32'd0);
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h2008_0005;
        tick();
        imem.imem_rvalid = 1'b0;
        check("f1_instr", InstrF, 32'h2008_0005);
        check("f1_pc4",   PCPlus4F, 32'h4);
        check("f1_valid", {31'b0, InstrValidF}, 32'd1);
        check("f1_busy",  {31'b0, FetchBusy}, 32'd0);

        // Stall in DELIVER holds everything and issues no request.
        StallF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_instr", InstrF, 32'h2008_0005);
            check("stall_pc4",   PCPlus4F, 32'h4);
            check("stall_req",   {31'b0, imem.imem_req}, 32'd0);
            check("stall_addr",  imem.imem_addr, 32'h0);
            check("stall_valid", {31'b0, InstrValidF}, 32'd1);
        end
        StallF = 1'b0;
        tick();
        check("adv_req",   {31'b0, imem.imem_req}, 32'd1);
        check("adv_addr",  imem.imem_addr, 32'h4);
        check("adv_valid", {31'b0, InstrValidF}, 32'd0);
        check("adv_busy",  {31'b0, FetchBusy}, 32'd1);
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h1111_1111;
        tick();
        imem.imem_rvalid = 1'b0;
        check("f2_instr", InstrF, 32'h1111_1111);
        check("f2_pc4",   PCPlus4F, 32'h8);
        tick();
        check("f3_addr", imem.imem_addr, 32'h8);

        // Slow memory: request held while not ready, then a long response wait.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("slow_req",  {31'b0, imem.imem_req}, 32'd1);
            check("slow_addr", imem.imem_addr, 32'h8);
        end
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("slow_busy",  {31'b0, FetchBusy}, 32'd1);
            check("slow_valid", {31'b0, InstrValidF}, 32'd0);
            check("slow_noreq", {31'b0, imem.imem_req}, 32'd0);
        end
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h2222_2222;
        tick();
        imem.imem_rvalid = 1'b0;
        check("slow_instr", InstrF, 32'h2222_2222);
        check("slow_pc4",   PCPlus4F, 32'hC);
        check("slow_valid1", {31'b0, InstrValidF}, 32'd1);
        tick();
        check("f4_addr", imem.imem_addr, 32'hC);
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready = 1'b0;

        // Redirect while waiting: the late response must be dropped.
        PCSrcD    = 1'b1;
        PCBranchD = 32'h0000_0040;
        tick();
        PCSrcD = 1'b0;
        check("rw_req",  {31'b0, imem.imem_req}, 32'd0);
        check("rw_addr", imem.imem_addr, 32'h40);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem.imem_rvalid = 1'b0;
        check("rw_drop_valid", {31'b0, InstrValidF}, 32'd0);
        check("rw_drop_instr", InstrF, 32'h2222_2222);
        check("rw_req2",  {31'b0, imem.imem_req}, 32'd1);
        check("rw_addr2", imem.imem_addr, 32'h40);
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready = 1'b0;

        // Branch and jump together with rvalid in WAIT: branch target wins.
        PCSrcD    = 1'b1;
        PCBranchD = 32'h0000_0080;
        JumpD     = 1'b1;
        PCJumpD   = 32'h0000_0100;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h3333_3333;
        tick();
        PCSrcD = 1'b0;
        JumpD  = 1'b0;
        imem.imem_rvalid = 1'b0;
        check("prio_addr",  imem.imem_addr, 32'h80);
        check("prio_req",   {31'b0, imem.imem_req}, 32'd1);
        check("prio_valid", {31'b0, InstrValidF}, 32'd0);
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h4444_4444;
        tick();
        imem.imem_rvalid = 1'b0;
        check("prio_instr", InstrF, 32'h4444_4444);
        check("prio_pc4",   PCPlus4F, 32'h84);

        // Jump to an unaligned top-of-memory target, overriding a stall.
        StallF  = 1'b1;
        JumpD   = 1'b1;
        PCJumpD = 32'hFFFF_FFFE;
        tick();
        JumpD  = 1'b0;
        StallF = 1'b0;
        check("wrap_addr",  imem.imem_addr, 32'hFFFF_FFFC);
        check("wrap_valid", {31'b0, InstrValidF}, 32'd0);
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h5555_5555;
        tick();
        imem.imem_rvalid = 1'b0;
        check("wrap_instr", InstrF, 32'h5555_5555);
        check("wrap_pc4",   PCPlus4F, 32'h0);
        tick();
        check("wrap_next_addr", imem.imem_addr, 32'h0);

        // Jump during an accepted request, then async reset while waiting.
        JumpD   = 1'b1;
        PCJumpD = 32'h0000_0200;
        imem.imem_ready = 1'b1;
        tick();
        JumpD = 1'b0;
        imem.imem_ready = 1'b0;
        check("rq_jump_addr", imem.imem_addr, 32'h200);
        check("rq_jump_req",  {31'b0, imem.imem_req}, 32'd0);
        #2;
        RST = 1'b1;
        #1;
        check("arst_instr", InstrF, 32'h0);
        check("arst_pc4",   PCPlus4F, 32'h0);
        check("arst_addr",  imem.imem_addr, 32'h0);
        check("arst_busy",  {31'b0, FetchBusy}, 32'd1);
        check("arst_req",   {31'b0, imem.imem_req}, 32'd0);
        tick();
        RST = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h6666_6666;
        tick();
        imem.imem_rvalid = 1'b0;
        check("stale_valid", {31'b0, InstrValidF}, 32'd0);
        check("stale_instr", InstrF, 32'h0);
        check("stale_req",   {31'b0, imem.imem_req}, 32'd1);
        check("stale_addr",  imem.imem_addr, 32'h0);
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h2008_0005;
        tick();
        imem.imem_rvalid = 1'b0;
        check("restart_instr", InstrF, 32'h2008_0005);
        check("restart_pc4",   PCPlus4F, 32'h4);
        check("restart_valid", {31'b0, InstrValidF}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
